// File: rtl/freq_sel_pkg.sv
// Shared types and constants for the frequency-ring random-read arbiter.
package freq_sel_pkg;

    localparam int unsigned ADDR_W_DEF   = 7;
    localparam int unsigned DATA_W_DEF   = 14;
    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned DRAIN_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching cyclically from ptr+1.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!grant_any && req[cand]) begin
                grant_any      = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/ring_rand_arb.sv
// Round-robin arbiter sharing the ring's random-read port among N_REQ requesters,
// with range check against the fill count and timeout/drain recovery.
module ring_rand_arb
    import freq_sel_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    resp_err,
    input  logic [ADDR_W-1:0]       ring_count,
    output logic [ADDR_W-1:0]       rand_rd_addr,
    output logic                    rand_rd_en,
    input  logic                    rand_rd_valid,
    input  logic [DATA_W-1:0]       ring_dout,
    output logic                    busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMR_W = 16;

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [N_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic                busy_q, busy_d;

    logic [N_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [ADDR_W-1:0]   pick_addr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    always_comb begin
        pick_addr = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) pick_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Next-state and transaction bookkeeping.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q;
        timer_d  = timer_q;
        drain_d  = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d    = pick_idx;
                    rr_ptr_d = pick_idx;
                    addr_d   = pick_addr;
                    if (pick_addr >= ring_count) begin
                        // Out-of-range takes a single DRAIN cycle so its response lands at T+2.
                        err_d   = 1'b1;
                        data_d  = '0;
                        drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
                        state_d = ST_DRAIN;
                    end else begin
                        timer_d = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (rand_rd_valid) begin
                    data_d  = ring_dout;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = ST_RESP;
                else                                       drain_d = drain_q + DRAIN_W'(1);
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are derived from the upcoming state so they align with it.
    always_comb begin
        rd_en_d      = (state_d == ST_ISSUE);
        rd_addr_d    = (state_d == ST_ISSUE) ? addr_d : rd_addr_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_err_d   = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        if (state_d == ST_RESP) begin
            resp_valid_d[gnt_d] = 1'b1;
            resp_data_d         = data_d;
            resp_err_d          = err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= IDX_W'(N_REQ - 1);
            gnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            timer_q      <= '0;
            drain_q      <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            drain_q      <= drain_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    // Grant handshake is combinational; held off while reset is asserted.
    assign req_ready    = (state_q == ST_IDLE && !rst) ? pick_oh : '0;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_err     = resp_err_q;
    assign rand_rd_addr = rd_addr_q;
    assign rand_rd_en   = rd_en_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ring_rand_arb.sv
// Self-checking bench for ring_rand_arb: ring model, transaction-level reference, directed + random stimulus.
module tb_ring_rand_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 14;
    localparam int unsigned TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready, resp_valid;
    logic [DW-1:0]   resp_data;
    logic            resp_err;
    logic [AW-1:0]   ring_count = '0;
    logic [AW-1:0]   rand_rd_addr;
    logic            rand_rd_en;
    logic            rand_rd_valid = 1'b0;
    logic [DW-1:0]   ring_dout = '0;
    logic            busy;

    ring_rand_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .ring_count(ring_count), .rand_rd_addr(rand_rd_addr),
        .rand_rd_en(rand_rd_en), .rand_rd_valid(rand_rd_valid), .ring_dout(ring_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0, cyc = 0;

    // Ring model: accepts en while not busy, answers after a latency.
    logic [DW-1:0] mem [128];
    bit            ring_busy = 0, ring_stuck = 0, rand_lat = 0, noise = 0, inject = 0;
    int            ring_due = 0, ring_lat = 2;
    logic [AW-1:0] ring_a = '0;
    int            lat_tab [7] = '{1, 2, 2, 3, 7, 8, 20};

    // Reference: one transaction record with absolute-cycle milestones.
    bit            m_busy, m_issue, m_err;
    int            m_rr, m_g, m_start, m_resp;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_last;
    logic [N-1:0]  m_gnt_prev;

    int            g_idx[$], g_cyc[$], r_cyc[$];
    logic [N-1:0]  r_vec[$];
    logic [DW-1:0] r_data[$];
    logic          r_err[$];
    int            en_cnt, en_first, en_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 40) $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_pick();
        logic [N-1:0] oh = '0;
        if (!m_busy) begin
            for (int k = 1; k <= int'(N); k++) begin
                int j;
                j = (m_rr + k) % int'(N);
                if (req_valid[j]) begin
                    oh[j] = 1'b1;
                    break;
                end
            end
        end
        return oh;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_issue = 0; m_err = 0; m_rr = N - 1; m_g = 0; m_start = 0; m_resp = -1;
        m_addr = '0; m_data = '0; m_last = '0; m_gnt_prev = '0; ring_busy = 0;
    endtask

    task automatic clear_logs();
        g_idx.delete(); g_cyc.delete(); r_cyc.delete(); r_vec.delete(); r_data.delete(); r_err.delete();
        en_cnt = 0; en_first = -1; en_last = -1;
    endtask

    task automatic model_update(input logic [N-1:0] eg);
        if (!m_busy) begin
            if (eg != '0) begin
                m_g = oh2i(eg); m_rr = m_g; m_addr = req_addr[m_g*AW +: AW]; m_busy = 1;
                if (m_addr >= ring_count) begin
                    m_issue = 0; m_err = 1; m_data = '0; m_resp = cyc + 2;
                end else begin
                    m_issue = 1; m_start = cyc; m_resp = -1;
                end
            end
        end else if (m_issue) begin
            if (rand_rd_valid) begin
                m_issue = 0; m_err = 0; m_data = ring_dout; m_resp = cyc + 1;
            end else if (cyc == m_start + int'(TO)) begin
                m_issue = 0; m_err = 1; m_data = '0; m_resp = cyc + 4;
            end
        end else if (cyc == m_resp) begin
            m_busy = 0; m_last = m_data;
        end
    endtask

    task automatic ring_drive();
        if (ring_busy && cyc == ring_due) begin
            rand_rd_valid = 1'b1; ring_dout = mem[ring_a];
        end else if (inject || (noise && !(m_busy && m_issue) && $urandom_range(7) == 0)) begin
            rand_rd_valid = 1'b1; ring_dout = DW'($urandom);
        end else begin
            rand_rd_valid = 1'b0; ring_dout = DW'($urandom);
        end
        inject = 0;
    endtask

    task automatic ring_sample();
        if (ring_busy) begin
            if (cyc == ring_due) ring_busy = 0;
        end else if (rand_rd_en && !ring_stuck) begin
            ring_busy = 1; ring_a = rand_rd_addr;
            ring_due  = cyc + (rand_lat ? lat_tab[$urandom_range(6)] : ring_lat);
        end
    endtask

    // One clock: inputs for this cycle are already driven by the caller.
    task automatic cycle();
        logic [N-1:0]  eg, er;
        logic [DW-1:0] ed;
        ring_drive();
        @(negedge clk);
        eg = model_pick();
        er = (m_busy && cyc == m_resp) ? N'(1 << m_g) : '0;
        ed = (m_busy && cyc == m_resp) ? m_data : m_last;
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("rand_rd_en", 32'(rand_rd_en), 32'(m_busy && m_issue));
        if (m_busy && m_issue) chk("rand_rd_addr", 32'(rand_rd_addr), 32'(m_addr));
        chk("resp_valid", 32'(resp_valid), 32'(er));
        if (er != '0) chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("resp_data", 32'(resp_data), 32'(ed));
        chk("busy", 32'(busy), 32'(m_busy));
        if (req_ready != '0) begin g_idx.push_back(oh2i(req_ready)); g_cyc.push_back(cyc); end
        if (resp_valid != '0) begin
            r_cyc.push_back(cyc); r_vec.push_back(resp_valid); r_data.push_back(resp_data); r_err.push_back(resp_err);
        end
        if (rand_rd_en) begin
            if (en_cnt == 0) en_first = cyc;
            en_last = cyc; en_cnt++;
        end
        ring_sample();
        model_update(eg);
        m_gnt_prev = eg;
        @(posedge clk); #1; cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_grant(input int i, output int t);
        t = -1;
        for (int b = 0; b < 60; b++) begin
            cycle();
            if (m_gnt_prev[i]) begin t = cyc - 1; break; end
        end
        if (t < 0) begin
            nvec++; nerr++;
            $display("FAIL grant_wait req%0d: got no grant, expected one within 60 cycles", i);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rand_rd_en"}, 32'(rand_rd_en), 32'h0);
        chk({tag, "_rand_rd_addr"}, 32'(rand_rd_addr), 32'h0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'h0);
        chk({tag, "_resp_data"}, 32'(resp_data), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected one before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t1, t2, e1;
        logic [N-1:0] exp_order [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
        mem[5] = 14'h1234;
        model_reset();
        clear_logs();

        // Reset state, with requests pending.
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        req_valid = '0;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // In-range read, idle ring, latency 2.
        clear_logs();
        ring_count = 100; req_addr[0*AW +: AW] = 5; req_valid = 4'b0001;
        wait_grant(0, t); req_valid = '0;
        run(8);
        chk("t1_grant_idx", 32'(g_idx.size() > 0 ? g_idx[0] : -1), 32'd0);
        chk("t1_en_first", 32'(en_first), 32'(t + 1));
        chk("t1_en_cnt", 32'(en_cnt), 32'd3);
        chk("t1_resp_n", 32'(r_cyc.size()), 32'd1);
        if (r_cyc.size() > 0) begin
            chk("t1_resp_cyc", 32'(r_cyc[0]), 32'(t + 4));
            chk("t1_resp_vec", 32'(r_vec[0]), 32'h1);
            chk("t1_resp_data", 32'(r_data[0]), 32'h1234);
            chk("t1_resp_err", 32'(r_err[0]), 32'h0);
        end

        // Out of range: addr == ring_count.
        clear_logs();
        ring_count = 10; req_addr[2*AW +: AW] = 10; req_valid = 4'b0100;
        wait_grant(2, t); req_valid = '0;
        run(6);
        chk("t2_en_cnt", 32'(en_cnt), 32'd0);
        chk("t2_resp_n", 32'(r_cyc.size()), 32'd1);
        if (r_cyc.size() > 0) begin
            chk("t2_resp_cyc", 32'(r_cyc[0]), 32'(t + 2));
            chk("t2_resp_vec", 32'(r_vec[0]), 32'h4);
            chk("t2_resp_err", 32'(r_err[0]), 32'h1);
        end

        // Stuck ring: timeout, drain, late valid ignored.
        clear_logs();
        ring_stuck = 1; ring_count = 100; req_addr[1*AW +: AW] = 3; req_valid = 4'b0010;
        wait_grant(1, t); req_valid = '0;
        for (int k = 0; k < 16; k++) begin
            if (cyc == t + 10) inject = 1;
            cycle();
        end
        ring_stuck = 0;
        chk("t3_en_first", 32'(en_first), 32'(t + 1));
        chk("t3_en_cnt", 32'(en_cnt), 32'(TO));
        chk("t3_resp_n", 32'(r_cyc.size()), 32'd1);
        if (r_cyc.size() > 0) begin
            chk("t3_resp_cyc", 32'(r_cyc[0]), 32'(t + 12));
            chk("t3_resp_err", 32'(r_err[0]), 32'h1);
            chk("t3_resp_data", 32'(r_data[0]), 32'h0);
        end

        // Reset pulsed during ISSUE.
        ring_stuck = 1; req_addr[3*AW +: AW] = 2; req_valid = 4'b1000;
        wait_grant(3, t);
        for (int i = 0; i < int'(N); i++) req_addr[i*AW +: AW] = AW'(i + 1);
        req_valid = 4'b1111;
        run(2);
        chk("t4_pre_en", 32'(rand_rd_en), 32'h1);
        #2; rst = 1; #1;
        chk_idle_outputs("t4_async");
        @(posedge clk); #1;
        req_valid = '0; ring_stuck = 0;
        @(negedge clk); rst = 0; model_reset();
        @(posedge clk); #1; cyc++;

        // All four held continuously: fair rotation from requester 0.
        clear_logs();
        req_valid = 4'b1111;
        for (int b = 0; b < 80 && g_idx.size() < 6; b++) cycle();
        req_valid = '0;
        run(8);
        chk("t4_grant_n", 32'(g_idx.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < g_idx.size()) chk("t4_grant_order", 32'(1 << g_idx[i]), 32'(exp_order[i]));

        // Back-to-back from one requester.
        clear_logs();
        ring_count = 100; req_addr[1*AW +: AW] = 3; req_valid = 4'b0010;
        wait_grant(1, t1);
        req_addr[1*AW +: AW] = 4;
        wait_grant(1, t2);
        e1 = en_last;
        req_valid = '0;
        run(8);
        chk("t5_en_last1", 32'(e1), 32'(t1 + 3));
        chk("t5_grant2_cyc", 32'(t2), 32'(t1 + 5));
        chk("t5_resp_n", 32'(r_cyc.size()), 32'd2);
        if (r_cyc.size() > 1) begin
            chk("t5_grant2_after_resp", 32'(t2), 32'(r_cyc[0] + 1));
            chk("t5_resp2_data", 32'(r_data[1]), 32'(mem[4]));
        end
        chk("t5_en_cnt", 32'(en_cnt), 32'd6);

        // Randomized traffic against the reference.
        rand_lat = 1; noise = 1;
        for (int n = 0; n < 3000; n++) begin
            if ((n % 16) == 0)
                ring_count = ($urandom_range(7) == 0) ? '0 : AW'($urandom_range(127));
            for (int i = 0; i < int'(N); i++) begin
                if (m_gnt_prev[i]) begin
                    req_valid[i] = $urandom_range(1);
                    req_addr[i*AW +: AW] = AW'($urandom_range(32'(ring_count) + 8));
                end else if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom_range(32'(ring_count) + 8));
                end else if (req_valid[i] && $urandom_range(39) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            cycle();
        end
        req_valid = '0;
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
